// File: rtl/window_line_buffer.sv
// Sliding-window column generator: KROWS-1 row stores cascade each accepted word
// into a vertical KROWS-tall column, one output column per input word once primed.
module window_line_buffer #(
    parameter int DATA_W    = 64,
    parameter int MAX_WIDTH = 8192,
    parameter int KROWS     = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               cfg_width,
    input  logic [31:0]               cfg_height,
    input  logic                      soft_clr,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [KROWS*DATA_W-1:0]   out_col,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_eol,
    output logic                      out_eof
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int NS = KROWS - 1;

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;
    state_t state, state_nx;

    logic [AW-1:0]            col_ptr, w_last, cfg_w_last, eff_w_last, wb_addr;
    logic [31:0]              row_cnt, h_last, cfg_h_last, eff_h_last;
    logic [DATA_W-1:0]        data_q;
    logic [NS*DATA_W-1:0]     old_flat, wb_flat, byp_q;
    logic [(NS+1)*DATA_W-1:0] shifted;
    logic                     accept, last_col, last_row;
    logic                     wb_pend, byp_sel, live;

    assign in_ready = rst_n && (!out_valid || out_ready) && !soft_clr;
    assign accept   = in_valid && in_ready;

    always_comb begin
        cfg_w_last = '0;
        if (cfg_width == 32'd0)
            cfg_w_last = '0;
        else if (cfg_width > 32'(MAX_WIDTH))
            cfg_w_last = AW'(MAX_WIDTH - 1);
        else
            cfg_w_last = AW'(cfg_width - 32'd1);
        cfg_h_last = (cfg_height < 32'(KROWS)) ? 32'(KROWS - 1) : cfg_height - 32'd1;
    end

    assign eff_w_last = (state == IDLE) ? cfg_w_last : w_last;
    assign eff_h_last = (state == IDLE) ? cfg_h_last : h_last;
    assign last_col   = (col_ptr == eff_w_last);
    assign last_row   = (row_cnt == eff_h_last);

    // The store write for an accept is deferred to the next accept so the old
    // read-first data can be cascaded; consecutive hits on one address bypass.
    assign shifted = {old_flat, data_q};
    assign wb_flat = shifted[NS*DATA_W-1:0];

    for (genvar g = 0; g < NS; g++) begin : g_row
        logic [DATA_W-1:0] mem [MAX_WIDTH];
        logic [DATA_W-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (accept) begin
                rd_q <= mem[col_ptr];
                if (wb_pend)
                    mem[wb_addr] <= wb_flat[g*DATA_W +: DATA_W];
            end
        end
        assign old_flat[g*DATA_W +: DATA_W] = byp_sel ? byp_q[g*DATA_W +: DATA_W] : rd_q;
    end

    assign out_col = live ? {old_flat, data_q} : '0;

    always_comb begin
        state_nx = state;
        if (soft_clr)
            state_nx = IDLE;
        else if (accept) begin
            if (last_col && last_row)
                state_nx = IDLE;
            else if (last_col && row_cnt == 32'(KROWS - 2))
                state_nx = STREAM;
            else if (state == IDLE)
                state_nx = PRIME;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_ptr   <= '0;
            row_cnt   <= '0;
            w_last    <= '0;
            h_last    <= '0;
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            data_q    <= '0;
            byp_q     <= '0;
            byp_sel   <= 1'b0;
            wb_addr   <= '0;
            wb_pend   <= 1'b0;
            live      <= 1'b0;
        end else if (soft_clr) begin
            col_ptr   <= '0;
            row_cnt   <= '0;
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                w_last <= cfg_w_last;
                h_last <= cfg_h_last;
            end
            if (last_col) begin
                col_ptr <= '0;
                row_cnt <= last_row ? '0 : row_cnt + 32'd1;
            end else begin
                col_ptr <= col_ptr + AW'(1);
            end
            out_valid <= (state == STREAM);
            out_eol   <= last_col;
            out_eof   <= last_col && last_row;
            data_q    <= in_data;
            byp_q     <= wb_flat;
            byp_sel   <= wb_pend && (wb_addr == col_ptr);
            wb_addr   <= col_ptr;
            wb_pend   <= 1'b1;
            live      <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/window_line_buffer.md
WINDOW_LINE_BUFFER -- requirements
Module: window_line_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning pixel word width in bits.
REQ-002 The block SHALL have parameter MAX_WIDTH, default 8192, meaning the physical depth of each row store in words.
REQ-003 The block SHALL have parameter KROWS, default 3, meaning window height in rows, legal range 2..7.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port cfg_width, input, 32 bits: row length in words (width x channels), sampled only at frame start.
REQ-007 Port cfg_height, input, 32 bits: frame height in rows, sampled only at frame start.
REQ-008 Port soft_clr, input, 1 bit: synchronous abort; returns the block to IDLE.
REQ-009 Port in_data, input, DATA_W bits: pixel word.
REQ-010 Port in_valid, input, 1 bit: in_data is valid.
REQ-011 Port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-012 Port out_col, output, KROWS*DATA_W bits: vertical column of the window. Bits [DATA_W-1:0] hold the newest row; the top slice holds the oldest row.
REQ-013 Port out_valid, output, 1 bit: out_col is valid.
REQ-014 Port out_ready, input, 1 bit: the downstream stage accepts out_col.
REQ-015 Port out_eol, output, 1 bit: out_col is the last column of its row.
REQ-016 Port out_eof, output, 1 bit: out_col is the last column of the frame.

Function
REQ-017 Storage SHALL be KROWS-1 row stores, each MAX_WIDTH x DATA_W, inferred as block RAM.
REQ-018 Row-store behaviour SHALL be synchronous and read-first.
REQ-019 Accept SHALL be defined as in_valid && in_ready.
REQ-020 in_ready SHALL equal (!out_valid || out_ready) && !soft_clr.
REQ-021 On accept, the block SHALL read every row store at col_ptr.
REQ-022 On accept, row store 0 SHALL be written with in_data.
REQ-023 On accept, row store i SHALL be written with the old value read from row store i-1, for i = 1..KROWS-2.
REQ-024 On accept, the output column SHALL be formed as {old store KROWS-2, ..., old store 0, in_data}.
REQ-025 Latency SHALL be 1 cycle: out_col, out_eol and out_eof are registered on the accepting edge.
REQ-026 While out_valid && !out_ready, out_col, out_valid, out_eol and out_eof SHALL hold stable, and no store access SHALL occur.
REQ-027 Effective width W SHALL be cfg_width clamped to the range 1..MAX_WIDTH; effective height H SHALL be cfg_height clamped to a minimum of KROWS.
REQ-028 col_ptr SHALL wrap from W-1 to 0 on accept, and row_cnt SHALL increment at each wrap.
REQ-029 When W=1, col_ptr SHALL remain 0.
REQ-030 The FSM SHALL have three states: IDLE, PRIME and STREAM.
REQ-031 IDLE -> PRIME SHALL occur on the first accept; W and H are latched on that edge and the word is processed as column 0.
REQ-032 PRIME -> STREAM SHALL occur on the accept that completes row KROWS-2.
REQ-033 STREAM -> IDLE SHALL occur on the accept of column W-1 of row H-1; col_ptr and row_cnt clear on that edge.
REQ-034 Words accepted in PRIME SHALL be stored only, with out_valid not set.
REQ-035 Words accepted in STREAM SHALL set out_valid.
REQ-036 out_eol SHALL be set when the accepted column is W-1.
REQ-037 out_eof SHALL be set when the accepted column is W-1 on row H-1.
REQ-038 An accept and a downstream drain in the same cycle SHALL both take effect, giving no bubble and full throughput.
REQ-039 On soft_clr, col_ptr, row_cnt, out_valid, out_eol and out_eof SHALL clear and the state SHALL become IDLE; soft_clr SHALL override a simultaneous accept.
REQ-040 Row-store contents SHALL NOT be cleared, because stale data is overwritten before use.

Reset
REQ-041 While rst_n=0, asynchronously, the following SHALL be 0: out_valid, out_eol, out_eof, out_col, col_ptr and row_cnt.
REQ-042 While rst_n=0, the state SHALL be IDLE and in_ready SHALL be 0.
REQ-043 After rst_n rises, in_ready SHALL be 1 from the first clock edge.
REQ-044 Reset asserted mid-frame SHALL discard the frame, and the next accept SHALL start a new frame.

Verification
REQ-045 Scenario: KROWS=3, W=4, H=4, data 0..15 streamed with out_ready=1 -> first out_valid follows word 8 with out_col={0,4,8}; 8 outputs in total; word 11 gives eol; word 15 gives {7,11,15} with eol and eof.
REQ-046 Scenario: same stream with out_ready toggling 1/0 each cycle -> identical output sequence, out_col held stable while stalled, no loss or duplication.
REQ-047 Scenario: W=1, H=3, data 5,6,7 -> single output {5,6,7} with eol and eof.
REQ-048 Scenario: cfg_width=0 and cfg_width=MAX_WIDTH+10 -> behaviour identical to W=1 and W=MAX_WIDTH respectively.
REQ-049 Scenario: soft_clr after word 9 of REQ-045, then a fresh frame 100..115 -> first output {100,104,108}, with no stale data appearing on any output.
REQ-050 Scenario: rst_n pulsed low asynchronously mid-frame, between clock edges -> outputs zero immediately; the next frame behaves exactly as in REQ-045.
